// File: rtl/bound_left_right_cut_if.sv
// ---------------------------------------------------------------------------
// bound_left_right_cut_if
// Video stream bundle for bound_left_right_cut: the padded input line, the
// cropped output line and the sticky line-length error flag.
//   din_vsync  : input frame-valid
//   din_hsync  : input line-valid (padded line, IW+KSZ-1 cycles)
//   din        : input pixel, qualified by din_hsync
//   dout_vsync : output frame-valid (din_vsync delayed one clock)
//   dout_hsync : output line-valid (IW cycles per well-formed line)
//   dout       : output pixel, qualified by dout_hsync
//   len_err    : sticky input line-length mismatch flag
// Modports: master = stream source / sink side, slave = cropping block side.
// ---------------------------------------------------------------------------
interface bound_left_right_cut_if #(
   parameter int DW = 8
);
   logic          din_vsync;
   logic          din_hsync;
   logic [DW-1:0] din;
   logic          dout_vsync;
   logic          dout_hsync;
   logic [DW-1:0] dout;
   logic          len_err;

   modport master (
      output din_vsync, din_hsync, din,
      input  dout_vsync, dout_hsync, dout, len_err
   );

   modport slave (
      input  din_vsync, din_hsync, din,
      output dout_vsync, dout_hsync, dout, len_err
   );
endinterface

// File: rtl/bound_left_right_cut.sv
// ---------------------------------------------------------------------------
// bound_left_right_cut
// Strips the PAD = (KSZ-1)/2 border pixels that a KSZ x KSZ window filter
// added on the left and right of every line, restoring lines of IW pixels.
// All outputs are registered: one clock of latency from din/din_hsync to
// dout/dout_hsync, and dout_vsync is din_vsync delayed one clock.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : bound_left_right_cut_if.slave (din_* in, dout_* / len_err out)
// Parameters: KSZ kernel edge (3, 5 or 7), DW pixel width, IW image width.
// ---------------------------------------------------------------------------
module bound_left_right_cut #(
   parameter int KSZ = 3,
   parameter int DW  = 8,
   parameter int IW  = 640
) (
   input logic                   clk,
   input logic                   rst,
   bound_left_right_cut_if.slave bus
);

   localparam int          PAD       = (KSZ - 1) / 2;
   localparam logic [13:0] COL_FIRST = 14'(PAD);
   localparam logic [13:0] COL_LAST  = 14'(PAD + IW - 1);
   localparam logic [13:0] LINE_LEN  = 14'(IW + KSZ - 1);
   localparam logic [13:0] COL_MAX   = 14'h3FFF;

   // UNARMED: just out of reset, waiting for a blank cycle so a line already
   // in progress is not treated as a line. IDLE: between lines. LINE: inside.
   typedef enum logic [1:0] {
      ST_UNARMED = 2'd0,
      ST_IDLE    = 2'd1,
      ST_LINE    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [13:0]   col_q;
   logic          active;
   logic          line_end;
   logic          keep;
   logic          vsync_rise;

   logic          vsync_q;
   logic          hsync_q;
   logic [DW-1:0] pix_q;
   logic          err_q;

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      active   = 1'b0;
      line_end = 1'b0;
      case (state_q)
         ST_UNARMED: begin
            if (!bus.din_hsync) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            active = bus.din_hsync;
            if (bus.din_hsync) state_d = ST_LINE;
         end
         ST_LINE: begin
            active   = bus.din_hsync;
            line_end = !bus.din_hsync;
            if (!bus.din_hsync) state_d = ST_IDLE;
         end
         default: state_d = ST_UNARMED;
      endcase
   end

   // col_q is the column index of the current input cycle; it is 0 on the
   // first high cycle because every low cycle forces it back to 0.
   assign keep       = active && (col_q >= COL_FIRST) && (col_q <= COL_LAST);
   assign vsync_rise = bus.din_vsync && !vsync_q;

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_UNARMED;
         col_q   <= '0;
         vsync_q <= 1'b0;
         hsync_q <= 1'b0;
         pix_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vsync_q <= bus.din_vsync;
         hsync_q <= keep;
         pix_q   <= keep ? bus.din : '0;

         if (active) col_q <= (col_q == COL_MAX) ? col_q : col_q + 14'd1;
         else        col_q <= '0;

         // At a line end col_q holds the number of high cycles in the line.
         // The set is tested first so it wins over a same-cycle frame start.
         if (line_end && (col_q != LINE_LEN)) err_q <= 1'b1;
         else if (vsync_rise)                 err_q <= 1'b0;
      end
   end

   assign bus.dout_vsync = vsync_q;
   assign bus.dout_hsync = hsync_q;
   assign bus.dout       = pix_q;
   assign bus.len_err    = err_q;

endmodule

// File: tb/tb_bound_left_right_cut.sv
// ---------------------------------------------------------------------------
// tb_bound_left_right_cut
// Drives two instances (KSZ=3 and KSZ=5, both IW=4) with the same input
// stream. A line-level model pushes the expected cropped pixels into per-
// instance queues; a monitor pops them whenever dout_hsync is high and also
// compares dout_vsync and len_err every clock.
// ---------------------------------------------------------------------------
module tb_bound_left_right_cut;

   localparam int DW   = 8;
   localparam int IW   = 4;
   localparam int PAD3 = 1;
   localparam int PAD5 = 2;
   localparam int LL3  = IW + 2;
   localparam int LL5  = IW + 4;

   logic clk;
   logic rst;

   bound_left_right_cut_if #(.DW(DW)) if3 ();
   bound_left_right_cut_if #(.DW(DW)) if5 ();

   bound_left_right_cut #(.KSZ(3), .DW(DW), .IW(IW)) u_k3 (
      .clk (clk),
      .rst (rst),
      .bus (if3)
   );

   bound_left_right_cut #(.KSZ(5), .DW(DW), .IW(IW)) u_k5 (
      .clk (clk),
      .rst (rst),
      .bus (if5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_pass   = 0;

   logic [DW-1:0] qp3[$];
   logic [DW-1:0] qp5[$];
   logic          qv3[$];
   logic          qv5[$];
   logic          err3 = 1'b0;
   logic          err5 = 1'b0;
   logic          last_vs = 1'b0;
   logic [DW-1:0] line_buf [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // One input cycle, driven on the falling edge.
   task automatic tick(input logic vs, input logic hs, input logic [DW-1:0] d, input logic r);
      @(negedge clk);
      rst           = r;
      if3.din_vsync = vs;  if5.din_vsync = vs;
      if3.din_hsync = hs;  if5.din_hsync = hs;
      if3.din       = d;   if5.din       = d;
      qv3.push_back(r ? 1'b0 : vs);
      qv5.push_back(r ? 1'b0 : vs);
      if (r || (vs && !last_vs)) begin
         err3 = 1'b0;
         err5 = 1'b0;
      end
      last_vs = r ? 1'b0 : vs;
   endtask

   // Expected pixels of a line cut off after 'upto' columns.
   task automatic expect_line(input int len, input int upto);
      for (int c = PAD3; c < len && c < upto && c < PAD3 + IW; c++) qp3.push_back(line_buf[c]);
      for (int c = PAD5; c < len && c < upto && c < PAD5 + IW; c++) qp5.push_back(line_buf[c]);
   endtask

   task automatic send_line(input int len, input logic vs_line, input logic vs_gap, input int ngap);
      expect_line(len, len);
      for (int c = 0; c < len; c++) tick(vs_line, 1'b1, line_buf[c], 1'b0);
      tick(vs_gap, 1'b0, '0, 1'b0);
      // Applied after the gap cycle's frame-start clear: a bad length wins.
      if (len > 0) begin
         if (len != LL3) err3 = 1'b1;
         if (len != LL5) err5 = 1'b1;
      end
      for (int g = 1; g < ngap; g++) tick(vs_gap, 1'b0, '0, 1'b0);
   endtask

   // Reset pulsed at column 'a'; released with din_hsync still high.
   task automatic abort_line(input int len, input int a, input logic vs);
      expect_line(len, a);
      for (int c = 0; c < a; c++) tick(vs, 1'b1, line_buf[c], 1'b0);
      tick(vs, 1'b1, line_buf[a], 1'b1);
      for (int c = a + 1; c < len; c++) tick(vs, 1'b1, line_buf[c], 1'b0);
      tick(vs, 1'b0, '0, 1'b0);
   endtask

   task automatic fill_ramp(input int start);
      for (int i = 0; i < 16; i++) line_buf[i] = DW'(start + i);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 16; i++) line_buf[i] = DW'($urandom);
   endtask

   // Monitor: compares outputs one time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (qv3.size() > 0) begin
            check("k3_vsync", 32'(if3.dout_vsync), 32'(qv3.pop_front()));
            check("k3_len_err", 32'(if3.len_err), 32'(err3));
            if (if3.dout_hsync === 1'b1) begin
               if (qp3.size() == 0) begin
                  n_checks++;
                  $display("FAIL k3_extra_pixel: got %0h expected no pixel at %0t", if3.dout, $time);
               end else check("k3_pixel", 32'(if3.dout), 32'(qp3.pop_front()));
            end else begin
               check("k3_hsync", 32'(if3.dout_hsync), 32'd0);
               check("k3_idle_dout", 32'(if3.dout), 32'd0);
            end
         end
         if (qv5.size() > 0) begin
            check("k5_vsync", 32'(if5.dout_vsync), 32'(qv5.pop_front()));
            check("k5_len_err", 32'(if5.len_err), 32'(err5));
            if (if5.dout_hsync === 1'b1) begin
               if (qp5.size() == 0) begin
                  n_checks++;
                  $display("FAIL k5_extra_pixel: got %0h expected no pixel at %0t", if5.dout, $time);
               end else check("k5_pixel", 32'(if5.dout), 32'(qp5.pop_front()));
            end else begin
               check("k5_hsync", 32'(if5.dout_hsync), 32'd0);
               check("k5_idle_dout", 32'(if5.dout), 32'd0);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      // Reset, then idle cycles that arm both instances.
      tick(1'b0, 1'b0, '0, 1'b1);
      tick(1'b0, 1'b0, '0, 1'b1);
      repeat (3) tick(1'b0, 1'b0, '0, 1'b0);

      // Frame start, then a well-formed KSZ=3 line 10..15.
      tick(1'b1, 1'b0, '0, 1'b0);
      fill_ramp(10);
      send_line(6, 1'b1, 1'b1, 2);

      // Ramp 0..7: well-formed for KSZ=5, long line for KSZ=3.
      fill_ramp(0);
      send_line(8, 1'b1, 1'b1, 2);

      // Frame end and new frame start clear the flags.
      repeat (3) tick(1'b0, 1'b0, '0, 1'b0);
      tick(1'b1, 1'b0, '0, 1'b0);

      // Short line 20..23.
      fill_ramp(20);
      send_line(4, 1'b1, 1'b1, 3);

      // Back-to-back lines with a single-cycle gap.
      fill_rand();
      send_line(6, 1'b1, 1'b1, 1);
      fill_rand();
      send_line(6, 1'b1, 1'b1, 1);

      // Line end coinciding with a frame start: KSZ=3 line OK -> clear,
      // KSZ=5 length wrong -> set wins.
      repeat (2) tick(1'b0, 1'b0, '0, 1'b0);
      fill_rand();
      send_line(6, 1'b0, 1'b1, 2);
      // Bad length for both at a frame start.
      repeat (2) tick(1'b0, 1'b0, '0, 1'b0);
      fill_rand();
      send_line(5, 1'b0, 1'b1, 2);

      // Degenerate lines, processed with din_vsync low.
      fill_rand();
      send_line(1, 1'b0, 1'b0, 2);
      fill_rand();
      send_line(2, 1'b0, 1'b0, 2);

      // Reset mid-line, then a normal line.
      fill_rand();
      abort_line(6, 2, 1'b1);
      fill_rand();
      send_line(6, 1'b1, 1'b1, 2);

      // Randomized lines, gaps and frame-valid levels.
      for (int n = 0; n < 40; n++) begin
         fill_rand();
         send_line(int'($urandom_range(0, 11)), 1'($urandom), 1'($urandom),
                   int'($urandom_range(1, 3)));
      end

      repeat (4) tick(1'b0, 1'b0, '0, 1'b0);
      @(posedge clk);
      #2;
      check("k3_missing_pixels", 32'(qp3.size()), 32'd0);
      check("k5_missing_pixels", 32'(qp5.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
